// File: rtl/main_memory_arbiter_if.sv
// Bus bundle shared by the main-memory arbiter, both cache controllers and
// main memory. The slave modport is the arbiter's view; the master modport is
// the view of everything around it (caches plus memory).
interface main_memory_arbiter_if #(
  parameter int ADDR_WIDTH = 28,
  parameter int LINE_WIDTH = 128
);
  // instruction cache side (read-only refills)
  logic                  I_MEM_READ;
  logic [ADDR_WIDTH-1:0] I_MEM_ADDRESS;
  logic [LINE_WIDTH-1:0] I_MEM_READ_DATA;
  logic                  I_MEM_BUSY_WAIT;

  // data cache side (refills and write-backs)
  logic                  D_MEM_READ;
  logic                  D_MEM_WRITE;
  logic [ADDR_WIDTH-1:0] D_MEM_ADDRESS;
  logic [LINE_WIDTH-1:0] D_MEM_WRITE_DATA;
  logic [LINE_WIDTH-1:0] D_MEM_READ_DATA;
  logic                  D_MEM_BUSY_WAIT;

  // main memory side
  logic                  MAIN_MEM_READ;
  logic                  MAIN_MEM_WRITE;
  logic [ADDR_WIDTH-1:0] MAIN_MEM_ADDRESS;
  logic [LINE_WIDTH-1:0] MAIN_MEM_WRITE_DATA;
  logic [LINE_WIDTH-1:0] MAIN_MEM_READ_DATA;
  logic                  MAIN_MEM_BUSY_WAIT;

  modport slave (
    input  I_MEM_READ, I_MEM_ADDRESS,
    output I_MEM_READ_DATA, I_MEM_BUSY_WAIT,
    input  D_MEM_READ, D_MEM_WRITE, D_MEM_ADDRESS, D_MEM_WRITE_DATA,
    output D_MEM_READ_DATA, D_MEM_BUSY_WAIT,
    output MAIN_MEM_READ, MAIN_MEM_WRITE, MAIN_MEM_ADDRESS, MAIN_MEM_WRITE_DATA,
    input  MAIN_MEM_READ_DATA, MAIN_MEM_BUSY_WAIT
  );

  modport master (
    output I_MEM_READ, I_MEM_ADDRESS,
    input  I_MEM_READ_DATA, I_MEM_BUSY_WAIT,
    output D_MEM_READ, D_MEM_WRITE, D_MEM_ADDRESS, D_MEM_WRITE_DATA,
    input  D_MEM_READ_DATA, D_MEM_BUSY_WAIT,
    input  MAIN_MEM_READ, MAIN_MEM_WRITE, MAIN_MEM_ADDRESS, MAIN_MEM_WRITE_DATA,
    output MAIN_MEM_READ_DATA, MAIN_MEM_BUSY_WAIT
  );
endinterface

// File: rtl/main_memory_arbiter.sv
// main_memory_arbiter: shares the single line-wide main-memory port between
// the instruction cache (refills) and the data cache (refills, write-backs).
// One transaction at a time: IDLE grants and latches the winner, SERVE holds
// a registered strobe until memory stops stalling, DONE releases the owner's
// busy-wait for exactly one cycle.
//
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//   defined     -> ties go to the requester that was not served last
//   not defined -> fixed priority, the data cache always wins ties
module main_memory_arbiter #(
  parameter int ADDR_WIDTH = 28,
  parameter int LINE_WIDTH = 128
) (
  input  logic                 clock,
  input  logic                 reset,
  main_memory_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  state_t                state_q, state_d;
  owner_t                owner_q, owner_d;
  // registered memory strobes; while in SERVE they also encode the latched op
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  // line buffer feeding both caches' read data
  logic [LINE_WIDTH-1:0] line_q, line_d;

  logic i_req;
  logic d_req;
  logic tie_to_d;
  logic d_wins;

  assign i_req = bus.I_MEM_READ;
  // a write-back with a simultaneous read request is still one D request
  assign d_req = bus.D_MEM_READ | bus.D_MEM_WRITE;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 1 when the data cache received the most recent grant
  logic last_d_q, last_d_d;
  assign tie_to_d = ~last_d_q;
`else
  assign tie_to_d = 1'b1;
`endif

  // a lone requester always wins; on a tie the tie-break decides
  assign d_wins = d_req & (~i_req | tie_to_d);

  // next-state and datapath-capture decisions for every register
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    line_d  = line_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d_d = last_d_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_req | d_req) begin
          state_d = S_SERVE;
          if (d_wins) begin
            owner_d = OWN_D;
            addr_d  = bus.D_MEM_ADDRESS;
            // write wins over read when the data cache asserts both
            if (bus.D_MEM_WRITE) begin
              wr_d    = 1'b1;
              wdata_d = bus.D_MEM_WRITE_DATA;
            end else begin
              rd_d = 1'b1;
            end
          end else begin
            owner_d = OWN_I;
            addr_d  = bus.I_MEM_ADDRESS;
            rd_d    = 1'b1;
          end
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_d_d = d_wins;
`endif
        end
      end
      S_SERVE: begin
        // memory stalls in the first strobe cycle, so this cannot fire early
        if (!bus.MAIN_MEM_BUSY_WAIT) begin
          if (rd_q) line_d = bus.MAIN_MEM_READ_DATA;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // single release cycle, then force a gap before the next grant
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  // arbiter FSM and all registered outputs; reset abandons any transaction
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= OWN_NONE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      line_q  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_d_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      line_q  <= line_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_d_q <= last_d_d;
`endif
    end
  end

  assign bus.MAIN_MEM_READ       = rd_q;
  assign bus.MAIN_MEM_WRITE      = wr_q;
  assign bus.MAIN_MEM_ADDRESS    = addr_q;
  assign bus.MAIN_MEM_WRITE_DATA = wdata_q;

  assign bus.I_MEM_READ_DATA = line_q;
  assign bus.D_MEM_READ_DATA = line_q;

  // busy follows the request; only the owner sees it drop, and only in DONE
  assign bus.I_MEM_BUSY_WAIT = i_req & ~((state_q == S_DONE) & (owner_q == OWN_I));
  assign bus.D_MEM_BUSY_WAIT = d_req & ~((state_q == S_DONE) & (owner_q == OWN_D));

endmodule

// File: tb/tb_main_memory_arbiter.sv
// Bench for main_memory_arbiter: directed cache-agent stimulus, a small
// main-memory model, and a transaction-timeline model compared every cycle.
module tb_main_memory_arbiter;
  localparam int AW = 28;
  localparam int LW = 128;

  logic clock = 1'b0;
  logic reset = 1'b1;

  main_memory_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

  main_memory_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [LW-1:0] pat(input int a);
    return {4{32'hC0DE_0000 | a}};
  endfunction

  // ---------------- main memory model ----------------
  logic [LW-1:0] mem_arr [0:255];
  bit            mem_ready = 1'b0;
  int            mem_lat   = 5;
  int            mem_cnt   = 0;
  logic          strobe;

  assign strobe                 = bus.MAIN_MEM_READ | bus.MAIN_MEM_WRITE;
  assign bus.MAIN_MEM_BUSY_WAIT = strobe && (mem_cnt < mem_lat);
  assign bus.MAIN_MEM_READ_DATA = mem_arr[bus.MAIN_MEM_ADDRESS[7:0]];

  always @(posedge clock) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= (i == 16) ? {16{8'hA5}} : pat(i);
      mem_ready <= 1'b1;
    end else if (bus.MAIN_MEM_WRITE && !bus.MAIN_MEM_BUSY_WAIT) begin
      mem_arr[bus.MAIN_MEM_ADDRESS[7:0]] <= bus.MAIN_MEM_WRITE_DATA;
    end
    mem_cnt <= strobe ? mem_cnt + 1 : 0;
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic summary_and_fatal(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s timeout got=still-busy want=busy-release", nm);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "bench aborted");
  endtask

  // ---------------- timeline model + per-cycle compare ----------------
  // A grant decided at the end of cycle g with memory latency L gives:
  //   strobe in cycles g+1 .. g+L+1, release (DONE) in g+L+2,
  //   earliest next grant decided at the end of cycle g+L+3.
  bit            chk_en     = 1'b0;
  int            m_idle_from = 0;
  bit            m_have     = 1'b0;
  int            m_g = 0, m_L = 0, m_own = 0;   // owner: 1 = I, 2 = D
  bit            m_wr       = 1'b0;
  int            m_last     = 1;                // last served, resets to I
  logic [AW-1:0] m_addr     = '0;
  logic [LW-1:0] m_wdata    = '0;
  logic [LW-1:0] m_line     = '0;
  logic [LW-1:0] m_pend     = '0;

  always @(negedge clock) begin : model_cmp
    int   c;
    int   done_own;
    int   win;
    logic rd_e, wr_e, ireq, dreq;
    if (chk_en) begin
      c        = cyc;
      ireq     = bus.I_MEM_READ;
      dreq     = bus.D_MEM_READ | bus.D_MEM_WRITE;
      rd_e     = 1'b0;
      wr_e     = 1'b0;
      done_own = 0;
      if (reset) begin
        m_have      = 1'b0;
        m_addr      = '0;
        m_wdata     = '0;
        m_line      = '0;
        m_last      = 1;
        m_idle_from = c + 1;
      end else if (m_have) begin
        if (c == m_g + m_L + 2 && !m_wr) m_line = m_pend;
        rd_e     = !m_wr && (c >= m_g + 1) && (c <= m_g + m_L + 1);
        wr_e     =  m_wr && (c >= m_g + 1) && (c <= m_g + m_L + 1);
        done_own = (c == m_g + m_L + 2) ? m_own : 0;
      end
      chk("MAIN_MEM_READ",       LW'(bus.MAIN_MEM_READ),    LW'(rd_e));
      chk("MAIN_MEM_WRITE",      LW'(bus.MAIN_MEM_WRITE),   LW'(wr_e));
      chk("MAIN_MEM_ADDRESS",    LW'(bus.MAIN_MEM_ADDRESS), LW'(m_addr));
      chk("MAIN_MEM_WRITE_DATA", bus.MAIN_MEM_WRITE_DATA,   m_wdata);
      chk("I_MEM_READ_DATA",     bus.I_MEM_READ_DATA,       m_line);
      chk("D_MEM_READ_DATA",     bus.D_MEM_READ_DATA,       m_line);
      chk("I_MEM_BUSY_WAIT",     LW'(bus.I_MEM_BUSY_WAIT),  LW'(ireq && done_own != 1));
      chk("D_MEM_BUSY_WAIT",     LW'(bus.D_MEM_BUSY_WAIT),  LW'(dreq && done_own != 2));
      // arbitration decision taken at the end of this cycle
      if (!reset && c >= m_idle_from && (ireq || dreq)) begin
        if (ireq && dreq) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          win = (m_last == 1) ? 2 : 1;
`else
          win = 2;
`endif
        end else begin
          win = dreq ? 2 : 1;
        end
        m_have      = 1'b1;
        m_g         = c;
        m_L         = mem_lat;
        m_own       = win;
        m_last      = win;
        m_wr        = (win == 2) && bus.D_MEM_WRITE;
        m_addr      = (win == 2) ? bus.D_MEM_ADDRESS : bus.I_MEM_ADDRESS;
        if (m_wr) m_wdata = bus.D_MEM_WRITE_DATA;
        m_pend      = mem_arr[m_addr[7:0]];
        m_idle_from = c + mem_lat + 3;
      end
    end
  end

  // ---------------- cache agents ----------------
  int            order_q[$];
  int            i_last_w = 0, d_last_w = 0;
  logic [LW-1:0] i_last_data = '0;

  // counts busy cycles from the current one until the requester is released
  task automatic wait_low(input int who, output int w);
    w = 0;
    @(negedge clock);
    while ((who == 1) ? bus.I_MEM_BUSY_WAIT : bus.D_MEM_BUSY_WAIT) begin
      w++;
      if (w > 1000) summary_and_fatal((who == 1) ? "i_busy" : "d_busy");
      @(negedge clock);
    end
  endtask

  // entered just after a posedge; request stays high back-to-back across items
  task automatic i_agent(input int n, input logic [AW-1:0] a0);
    int w;
    for (int k = 0; k < n; k++) begin
      bus.I_MEM_ADDRESS = a0 + AW'(k);
      bus.I_MEM_READ    = 1'b1;
      wait_low(1, w);
      i_last_w    = w;
      i_last_data = bus.I_MEM_READ_DATA;
      order_q.push_back(1);
      @(posedge clock); #1;
    end
    bus.I_MEM_READ = 1'b0;
  endtask

  task automatic d_agent(input int n, input logic [AW-1:0] a0, input bit wr,
                         input logic [LW-1:0] wd);
    int w;
    for (int k = 0; k < n; k++) begin
      bus.D_MEM_ADDRESS    = a0 + AW'(k);
      bus.D_MEM_WRITE_DATA = wd;
      bus.D_MEM_READ       = !wr;
      bus.D_MEM_WRITE      = wr;
      wait_low(2, w);
      d_last_w = w;
      order_q.push_back(2);
      @(posedge clock); #1;
    end
    bus.D_MEM_READ  = 1'b0;
    bus.D_MEM_WRITE = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    int            w;
    int            exp_order[8];
    logic [LW-1:0] wd2, wd5;
    wd2 = {8{16'h1234}};
    wd5 = {4{32'hDEAD_BEEF}};
    bus.I_MEM_READ       = 1'b0;
    bus.I_MEM_ADDRESS    = '0;
    bus.D_MEM_READ       = 1'b0;
    bus.D_MEM_WRITE      = 1'b0;
    bus.D_MEM_ADDRESS    = '0;
    bus.D_MEM_WRITE_DATA = '0;

    // reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_read",  LW'(bus.MAIN_MEM_READ),    '0);
    chk("rst_write", LW'(bus.MAIN_MEM_WRITE),   '0);
    chk("rst_addr",  LW'(bus.MAIN_MEM_ADDRESS), '0);
    chk("rst_wdata", bus.MAIN_MEM_WRITE_DATA,   '0);
    chk("rst_line",  bus.I_MEM_READ_DATA,       '0);
    chk("rst_ibusy", LW'(bus.I_MEM_BUSY_WAIT),  '0);
    chk_en = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (2) @(posedge clock); #1;

    // 1: icache refill, 5-cycle memory
    mem_lat = 5;
    i_agent(1, AW'(28'h0000010));
    chk("t1_wait", LW'(i_last_w), LW'(7));
    chk("t1_data", i_last_data, {16{8'hA5}});
    chk("t1_addr", LW'(bus.MAIN_MEM_ADDRESS), LW'(28'h0000010));
    repeat (2) @(posedge clock); #1;

    // 2: dcache write-back leaves the line buffer alone
    d_agent(1, AW'(28'h0000020), 1'b1, wd2);
    chk("t2_wait",  LW'(d_last_w), LW'(7));
    chk("t2_wdata", bus.MAIN_MEM_WRITE_DATA, wd2);
    chk("t2_line",  bus.I_MEM_READ_DATA, {16{8'hA5}});
    chk("t2_mem",   mem_arr[8'h20], wd2);
    repeat (2) @(posedge clock); #1;

    // 3: continuous contention, four requests each
    mem_lat = 2;
    order_q.delete();
    fork
      i_agent(4, AW'(28'h0000080));
      d_agent(4, AW'(28'h0000060), 1'b0, '0);
    join
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_order = '{2, 1, 2, 1, 2, 1, 2, 1};
`else
    exp_order = '{2, 2, 2, 2, 1, 1, 1, 1};
`endif
    chk("t3_count", LW'(order_q.size()), LW'(8));
    for (int k = 0; k < 8; k++)
      chk($sformatf("t3_order%0d", k),
          LW'((k < order_q.size()) ? order_q[k] : 0), LW'(exp_order[k]));
    chk("t3_last_i_data", i_last_data, pat(8'h83));
    repeat (2) @(posedge clock); #1;

    // 4: reset in the third strobe cycle, request held and reissued
    mem_lat = 5;
    bus.I_MEM_ADDRESS = AW'(28'h0000030);
    bus.I_MEM_READ    = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("t4_read",  LW'(bus.MAIN_MEM_READ),    '0);
    chk("t4_addr",  LW'(bus.MAIN_MEM_ADDRESS), '0);
    chk("t4_line",  bus.I_MEM_READ_DATA,       '0);
    chk("t4_ibusy", LW'(bus.I_MEM_BUSY_WAIT),  LW'(1));
    @(posedge clock); #1;
    reset = 1'b0;
    wait_low(1, w);
    chk("t4_wait", LW'(w), LW'(7));
    chk("t4_data", bus.I_MEM_READ_DATA, pat(8'h30));
    @(posedge clock); #1;
    bus.I_MEM_READ = 1'b0;
    repeat (2) @(posedge clock); #1;

    // 5: read+write together is a write; owner drops mid-SERVE
    bus.D_MEM_ADDRESS    = AW'(28'h0000040);
    bus.D_MEM_WRITE_DATA = wd5;
    bus.D_MEM_READ       = 1'b1;
    bus.D_MEM_WRITE      = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    bus.D_MEM_READ    = 1'b0;
    bus.D_MEM_WRITE   = 1'b0;
    bus.I_MEM_ADDRESS = AW'(28'h0000050);
    bus.I_MEM_READ    = 1'b1;
    wait_low(1, w);
    chk("t5_i_wait", LW'(w), LW'(12));
    chk("t5_i_data", bus.I_MEM_READ_DATA, pat(8'h50));
    chk("t5_mem",    mem_arr[8'h40], wd5);
    @(posedge clock); #1;
    bus.I_MEM_READ = 1'b0;
    repeat (3) @(posedge clock); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
